// File: rtl/uart_tx_fmt.sv
// UART transmit formatter for debug print requests.
// Sends one ASCII char or a 32-bit word as 8 uppercase hex digits on an 8N1 line, then acks once.
module uart_tx_fmt #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] din_tx,
  output logic        ack_tx,
  output logic        busy,
  output logic        txd
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [3:0]    char_cnt, char_cnt_n;
  logic [3:0]    n_chars;
  logic [31:0]   shift_word;
  logic [7:0]    char_reg;
  logic          is_hex;
  logic          armed;
  logic          accept;
  logic          baud_tick;
  logic          txd_n;
  logic [3:0]    nib;
  logic [7:0]    hex_char;

  assign nib       = shift_word[31:28];
  assign hex_char  = (nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h37 + {4'd0, nib});
  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign ack_tx    = (state == DONE);

  always_comb begin
    state_n    = state;
    bit_n      = bit_cnt;
    char_cnt_n = char_cnt;
    baud_n     = '0;
    accept     = 1'b0;
    txd_n      = 1'b1;
    case (state)
      IDLE: begin
        if (armed && req_tx) begin
          state_n = LOAD;
          accept  = 1'b1;
        end
      end
      LOAD: state_n = START;
      START: begin
        if (baud_tick) begin
          state_n = DATA;
          bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == 3'd7) state_n = STOP;
          else bit_n = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          char_cnt_n = char_cnt + 4'd1;
          state_n    = (char_cnt_n == n_chars) ? DONE : LOAD;
        end
      end
      DONE: begin
        state_n    = IDLE;
        char_cnt_n = 4'd0;
      end
      default: state_n = IDLE;
    endcase

    // Baud counter restarts on every state entry and on each data bit boundary.
    if ((state_n == state) && !baud_tick &&
        ((state == START) || (state == DATA) || (state == STOP)))
      baud_n = baud_cnt + BW'(1);

    // txd is computed from the upcoming state so the register output matches it exactly.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = char_reg[bit_n];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      char_cnt <= 4'd0;
      txd      <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      char_cnt <= char_cnt_n;
      txd      <= txd_n;
    end
  end

  // Re-arming only happens in IDLE, so a level request held through ack is not re-accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed      <= 1'b1;
      busy       <= 1'b0;
      shift_word <= 32'd0;
      n_chars    <= 4'd0;
      is_hex     <= 1'b0;
      char_reg   <= 8'd0;
    end else begin
      if (accept) begin
        shift_word <= din_tx;
        is_hex     <= type_tx;
        n_chars    <= type_tx ? 4'd8 : 4'd1;
        busy       <= 1'b1;
        armed      <= 1'b0;
      end else if ((state == IDLE) && !req_tx) begin
        armed <= 1'b1;
      end
      if (state == LOAD) begin
        char_reg <= is_hex ? hex_char : shift_word[7:0];
        if (is_hex) shift_word <= shift_word << 4;
      end
      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fmt.sv
// Directed testbench for uart_tx_fmt at 16 clocks per bit.
// A small UART receiver samples mid-bit; latencies are counted in clocks from the request.
module tb_uart_tx_fmt;

  logic        clk;
  logic        rstn;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din_tx;
  logic        ack_tx;
  logic        busy;
  logic        txd;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ack_count = 0;
  int lat;
  int rx_cnt;
  logic [7:0] rx_buf[8];
  logic [9:0] rx_frame[8];

  uart_tx_fmt #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req_tx (req_tx),
    .type_tx(type_tx),
    .din_tx (din_tx),
    .ack_tx (ack_tx),
    .busy   (busy),
    .txd    (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ack_tx === 1'b1) ack_count++;

  // Receives n frames; each frame keeps start, 8 data bits and stop as sampled mid-bit.
  task automatic rx_frames(input int n);
    logic [9:0] frame;
    rx_cnt = 0;
    for (int c = 0; c < n; c++) begin
      int w = 0;
      while (txd !== 1'b0 && w < 4000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 4000) return;
      repeat (7) @(negedge clk);
      frame[0] = txd;
      for (int b = 1; b < 10; b++) begin
        repeat (16) @(negedge clk);
        frame[b] = txd;
      end
      rx_frame[c] = frame;
      rx_buf[c]   = frame[8:1];
      rx_cnt++;
    end
  endtask

  // Raises a request at the current falling edge and counts clocks up to the ack.
  task automatic run_request(input logic t, input logic [31:0] d, output int latency);
    req_tx  = 1'b1;
    type_tx = t;
    din_tx  = d;
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
      if (latency == 1) begin
        din_tx  = 32'h5555_5555;
        type_tx = ~t;
      end
    end while (ack_tx !== 1'b1 && latency < 20000);
    if (latency >= 20000) latency = -1;
  endtask

  task automatic drop_req();
    @(negedge clk);
    req_tx = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rx_word();
    logic [63:0] w = '0;
    for (int c = 0; c < 8; c++) w = {w[55:0], rx_buf[c]};
    return w;
  endfunction

  task automatic test_reset();
    logic ok;
    rstn = 1'b1; req_tx = 1'b0; type_tx = 1'b0; din_tx = 32'd0;
    #3 rstn = 1'b0;
    #2;
    total_cnt++;
    if (ack_tx !== 1'b0) $display("[TB] FAIL reset_ack: got %b expected 0", ack_tx); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (txd !== 1'b1) $display("[TB] FAIL reset_txd: got %b expected 1", txd); else pass_cnt++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || ack_tx !== 1'b0) ok = 1'b0;
    end
    total_cnt++;
    if (ok !== 1'b1) $display("[TB] FAIL reset_idle: got quiet=%b expected 1", ok); else pass_cnt++;
  endtask

  task automatic test_char();
    fork
      rx_frames(1);
      run_request(1'b0, 32'h0000_0049, lat);
    join
    total_cnt++;
    if (rx_cnt != 1 || rx_frame[0] !== 10'b1_0100_1001_0)
      $display("[TB] FAIL char_bits: got %b (frames %0d) expected 1010010010", rx_frame[0], rx_cnt);
    else pass_cnt++;
    total_cnt++;
    if (lat != 162) $display("[TB] FAIL char_latency: got %0d expected 162", lat); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("[TB] FAIL char_busy_at_ack: got %b expected 1", busy); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ack_tx !== 1'b0) $display("[TB] FAIL char_ack_width: got %b expected 0", ack_tx); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL char_busy_after: got %b expected 0", busy); else pass_cnt++;
    req_tx = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hex();
    fork
      rx_frames(8);
      run_request(1'b1, 32'h0000_1A2F, lat);
    join
    total_cnt++;
    if (rx_cnt != 8) $display("[TB] FAIL hex_count: got %0d expected 8", rx_cnt); else pass_cnt++;
    total_cnt++;
    if (rx_word() !== 64'h3030_3030_3141_3246)
      $display("[TB] FAIL hex_text: got %h expected 3030303031413246", rx_word());
    else pass_cnt++;
    total_cnt++;
    if (lat != 1289) $display("[TB] FAIL hex_latency: got %0d expected 1289", lat); else pass_cnt++;
    drop_req();
  endtask

  task automatic test_back_to_back();
    int acks0;
    logic quiet;
    acks0 = ack_count;
    fork
      rx_frames(1);
      run_request(1'b0, 32'h0000_0049, lat);
    join
    total_cnt++;
    if (rx_buf[0] !== 8'h49) $display("[TB] FAIL b2b_char_I: got %h expected 49", rx_buf[0]); else pass_cnt++;
    quiet = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1 || ack_tx !== 1'b0) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("[TB] FAIL b2b_held_req: got quiet=%b expected 1", quiet); else pass_cnt++;
    drop_req();
    fork
      rx_frames(1);
      run_request(1'b0, 32'h0000_002D, lat);
    join
    total_cnt++;
    if (rx_buf[0] !== 8'h2D) $display("[TB] FAIL b2b_char_dash: got %h expected 2d", rx_buf[0]); else pass_cnt++;
    drop_req();
    fork
      rx_frames(8);
      run_request(1'b1, 32'hC0DE_0042, lat);
    join
    total_cnt++;
    if (rx_word() !== 64'h4330_4445_3030_3432)
      $display("[TB] FAIL b2b_word: got %h expected 4330444530303432", rx_word());
    else pass_cnt++;
    drop_req();
    fork
      rx_frames(1);
      run_request(1'b0, 32'h0000_003A, lat);
    join
    total_cnt++;
    if (rx_buf[0] !== 8'h3A) $display("[TB] FAIL b2b_char_colon: got %h expected 3a", rx_buf[0]); else pass_cnt++;
    drop_req();
    total_cnt++;
    if (ack_count - acks0 != 4) $display("[TB] FAIL b2b_ack_count: got %0d expected 4", ack_count - acks0);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int acks0;
    logic quiet;
    req_tx = 1'b1; type_tx = 1'b1; din_tx = 32'hDEAD_BEEF;
    repeat (70) @(negedge clk);
    acks0 = ack_count;
    rstn = 1'b0;
    req_tx = 1'b0;
    #1;
    total_cnt++;
    if (txd !== 1'b1) $display("[TB] FAIL mid_reset_txd: got %b expected 1", txd); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1 || ack_count != acks0)
      $display("[TB] FAIL mid_reset_quiet: got quiet=%b acks=%0d expected 1 and 0", quiet, ack_count - acks0);
    else pass_cnt++;
    fork
      rx_frames(1);
      run_request(1'b0, 32'h0000_004B, lat);
    join
    total_cnt++;
    if (rx_cnt != 1 || rx_frame[0] !== 10'b1_0100_1011_0)
      $display("[TB] FAIL mid_reset_char: got %b expected 1010010110", rx_frame[0]);
    else pass_cnt++;
    total_cnt++;
    if (lat != 162) $display("[TB] FAIL mid_reset_latency: got %0d expected 162", lat); else pass_cnt++;
    drop_req();
  endtask

  task automatic test_extremes();
    fork
      rx_frames(8);
      run_request(1'b1, 32'h0000_0000, lat);
    join
    total_cnt++;
    if (rx_cnt != 8 || rx_word() !== 64'h3030_3030_3030_3030)
      $display("[TB] FAIL ext_zero: got %h expected 3030303030303030", rx_word());
    else pass_cnt++;
    drop_req();
    fork
      rx_frames(8);
      run_request(1'b1, 32'hFFFF_FFFF, lat);
    join
    total_cnt++;
    if (rx_cnt != 8 || rx_word() !== 64'h4646_4646_4646_4646)
      $display("[TB] FAIL ext_ones: got %h expected 4646464646464646", rx_word());
    else pass_cnt++;
    total_cnt++;
    if (lat != 1289) $display("[TB] FAIL ext_ones_latency: got %0d expected 1289", lat); else pass_cnt++;
    drop_req();
    fork
      rx_frames(1);
      run_request(1'b0, 32'hABCD_EF0D, lat);
    join
    total_cnt++;
    if (rx_cnt != 1 || rx_buf[0] !== 8'h0D) $display("[TB] FAIL ext_char_low_byte: got %h expected 0d", rx_buf[0]);
    else pass_cnt++;
    total_cnt++;
    if (lat != 162) $display("[TB] FAIL ext_char_latency: got %0d expected 162", lat); else pass_cnt++;
    drop_req();
  endtask

  initial begin
    test_reset();
    test_char();
    test_hex();
    test_back_to_back();
    test_reset_midframe();
    test_extremes();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
